oam_dma_controller: RTL and testbench

OAM_DMA_CONTROLLER -- requirements
Module: oam_dma_controller

---
 rtl/oam_dma_controller.sv | 137 +++++++++++++
 tb/tb_oam_dma_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_controller.sv
// oam_dma_controller
//   Copies DMA_LEN bytes from {src_hi, idx} on the system MMU into OAM,
//   one byte every two bus cycles, after the CPU writes the source high byte
//   to DMA_REG_ADDR. While idle, CPU accesses pass straight through to the
//   MMU; while a transfer owns the bus, CPU accesses are blocked.
//
// Ports
//   clk, reset              bus clock, async active-high reset
//   A_cpu, Di_cpu, Do_cpu   CPU address / write data / read data
//   wr_cpu, rd_cpu          CPU strobes
//   A_MMU, Do_MMU, Di_MMU   system MMU address / write data / read data
//   wr_MMU, rd_MMU          system MMU strobes
//   A_OAM, Do_OAM, wr_OAM   OAM byte index / write data / write strobe
//   dma_active              transfer owns the MMU bus
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no transfer; CPU passes through to the MMU
// S_DELAY | one dead cycle after the source register write
// S_READ  | read source byte {src_hi, idx} from the MMU into r_buf
// S_WRITE | write r_buf to OAM[idx]; advance idx or finish
module oam_dma_controller #(
  parameter int unsigned DMA_LEN      = 160,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A_cpu,
  input  logic [7:0]  Di_cpu,
  output logic [7:0]  Do_cpu,
  input  logic        wr_cpu,
  input  logic        rd_cpu,
  output logic [15:0] A_MMU,
  output logic [7:0]  Do_MMU,
  input  logic [7:0]  Di_MMU,
  output logic        wr_MMU,
  output logic        rd_MMU,
  output logic [7:0]  A_OAM,
  output logic [7:0]  Do_OAM,
  output logic        wr_OAM,
  output logic        dma_active
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_READ  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  state_t     r_state;
  logic [7:0] r_dma_reg;
  logic [7:0] r_idx;
  logic [7:0] r_buf;

  logic       w_is_reg;
  logic [7:0] w_src_hi;

  assign w_is_reg = (A_cpu == DMA_REG_ADDR);
  // Sources at E000 and above are echo RAM; fold them back onto C000-DDFF.
  assign w_src_hi = (r_dma_reg < 8'hE0) ? r_dma_reg : (r_dma_reg - 8'h20);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_dma_reg <= 8'h00;
      r_idx     <= 8'h00;
      r_buf     <= 8'h00;
    end else if (wr_cpu && w_is_reg) begin
      // A register write (re)starts the transfer from any state.
      r_dma_reg <= Di_cpu;
      r_idx     <= 8'h00;
      r_state   <= S_DELAY;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= S_IDLE;
        S_DELAY: r_state <= S_READ;
        S_READ: begin
          r_buf   <= Di_MMU;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (r_idx == LAST_IDX) begin
            r_state <= S_IDLE;
          end else begin
            r_idx   <= r_idx + 8'd1;
            r_state <= S_READ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dma_active = (r_state != S_IDLE);

  always_comb begin
    A_MMU  = 16'h0000;
    Do_MMU = 8'h00;
    wr_MMU = 1'b0;
    rd_MMU = 1'b0;
    Do_cpu = 8'h00;
    A_OAM  = 8'h00;
    Do_OAM = 8'h00;
    wr_OAM = 1'b0;

    // CPU side: the source register is local and never forwarded.
    if (w_is_reg) begin
      Do_cpu = r_dma_reg;
    end else if (r_state == S_IDLE) begin
      A_MMU  = A_cpu;
      wr_MMU = wr_cpu;
      rd_MMU = rd_cpu;
      Do_MMU = wr_cpu ? Di_cpu : 8'h00;
      Do_cpu = Di_MMU;
    end else begin
      Do_cpu = 8'hFF;
    end

    // DMA side owns the MMU bus and OAM port outside idle.
    case (r_state)
      S_READ: begin
        A_MMU  = {w_src_hi, r_idx};
        rd_MMU = 1'b1;
      end
      S_WRITE: begin
        wr_OAM = 1'b1;
        A_OAM  = r_idx;
        Do_OAM = r_buf;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
module tb_oam_dma_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] A_cpu = 16'h0000;
  logic [7:0]  Di_cpu = 8'h00;
  logic        wr_cpu = 1'b0;
  logic        rd_cpu = 1'b0;
  logic [7:0]  Do_cpu;
  logic [15:0] A_MMU;
  logic [7:0]  Do_MMU;
  logic [7:0]  Di_MMU;
  logic        wr_MMU, rd_MMU;
  logic [7:0]  A_OAM, Do_OAM;
  logic        wr_OAM, dma_active;

  logic        mmu_force = 1'b0;
  logic [7:0]  mmu_val = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  // Observations recorded by the monitor; expectations queued by the tests.
  logic [15:0] oam_obs[$];
  logic [15:0] src_obs[$];
  logic [15:0] exp_oam[$];
  logic [15:0] exp_src[$];
  int cyc_cnt = 0, act_total = 0, last_act_cyc = 0, last_woam_cyc = 0, stray_wr = 0;
  int w_cyc = 0;

  oam_dma_controller dut (
    .clk(clk), .reset(reset),
    .A_cpu(A_cpu), .Di_cpu(Di_cpu), .Do_cpu(Do_cpu),
    .wr_cpu(wr_cpu), .rd_cpu(rd_cpu),
    .A_MMU(A_MMU), .Do_MMU(Do_MMU), .Di_MMU(Di_MMU),
    .wr_MMU(wr_MMU), .rd_MMU(rd_MMU),
    .A_OAM(A_OAM), .Do_OAM(Do_OAM), .wr_OAM(wr_OAM),
    .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  // MMU model: returns the low address byte unless a test forces a value.
  assign Di_MMU = mmu_force ? mmu_val : A_MMU[7:0];

  // Inputs change on the falling edge; sample settled outputs 2 ns later.
  always @(negedge clk) begin
    #2;
    cyc_cnt++;
    if (wr_OAM) begin
      oam_obs.push_back({A_OAM, Do_OAM});
      last_woam_cyc = cyc_cnt;
    end
    if (dma_active && rd_MMU) src_obs.push_back(A_MMU);
    if (dma_active && wr_MMU) stray_wr++;
    if (dma_active) begin
      act_total++;
      last_act_cyc = cyc_cnt;
    end
  end

  task automatic write_dma(input logic [7:0] v);
    @(negedge clk);
    A_cpu = 16'hFF46; Di_cpu = v; wr_cpu = 1'b1; rd_cpu = 1'b0;
    #3 w_cyc = cyc_cnt;
    @(negedge clk);
    A_cpu = 16'h0000; Di_cpu = 8'h00; wr_cpu = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_checks++; if (dma_active !== 1'b0) begin n_errors++; $display("FAIL reset_active got %b exp 0", dma_active); end
    n_checks++; if (wr_OAM !== 1'b0) begin n_errors++; $display("FAIL reset_wr_oam got %b exp 0", wr_OAM); end
    n_checks++; if ({A_OAM, Do_OAM} !== 16'h0000) begin n_errors++; $display("FAIL reset_oam_bus got %h exp 0000", {A_OAM, Do_OAM}); end
    n_checks++; if (Do_MMU !== 8'h00) begin n_errors++; $display("FAIL reset_do_mmu got %h exp 00", Do_MMU); end
    @(negedge clk);
    reset = 1'b0; A_cpu = 16'hFF46; rd_cpu = 1'b1;
    #1;
    n_checks++; if (Do_cpu !== 8'h00) begin n_errors++; $display("FAIL reset_dma_reg got %h exp 00", Do_cpu); end
    n_checks++; if (rd_MMU !== 1'b0) begin n_errors++; $display("FAIL reg_read_forwarded got %b exp 0", rd_MMU); end
    @(negedge clk);
    A_cpu = 16'h0000; rd_cpu = 1'b0;
  endtask

  task automatic test_passthrough;
    @(negedge clk);
    mmu_force = 1'b1; mmu_val = 8'h5A; A_cpu = 16'hC123; rd_cpu = 1'b1;
    #1;
    n_checks++; if (rd_MMU !== 1'b1) begin n_errors++; $display("FAIL pt_rd_mmu got %b exp 1", rd_MMU); end
    n_checks++; if (A_MMU !== 16'hC123) begin n_errors++; $display("FAIL pt_a_mmu got %h exp c123", A_MMU); end
    n_checks++; if (Do_cpu !== 8'h5A) begin n_errors++; $display("FAIL pt_do_cpu got %h exp 5a", Do_cpu); end
    n_checks++; if (dma_active !== 1'b0) begin n_errors++; $display("FAIL pt_active got %b exp 0", dma_active); end
    @(negedge clk);
    rd_cpu = 1'b0; wr_cpu = 1'b1; A_cpu = 16'h8123; Di_cpu = 8'h3C;
    #1;
    n_checks++; if ({wr_MMU, rd_MMU} !== 2'b10) begin n_errors++; $display("FAIL pt_wr_strobes got %b exp 10", {wr_MMU, rd_MMU}); end
    n_checks++; if ({A_MMU, Do_MMU} !== 24'h81233C) begin n_errors++; $display("FAIL pt_wr_bus got %h exp 81233c", {A_MMU, Do_MMU}); end
    @(negedge clk);
    wr_cpu = 1'b0; A_cpu = 16'h0000; Di_cpu = 8'h00; mmu_force = 1'b0;
  endtask

  task automatic test_transfer;
    int b_oam, b_src, b_act, i;
    logic [15:0] e, g;
    b_oam = oam_obs.size(); b_src = src_obs.size(); b_act = act_total;
    for (int k = 0; k < 160; k++) begin
      exp_oam.push_back({8'(k), 8'(k)});
      exp_src.push_back({8'hC1, 8'(k)});
    end
    write_dma(8'hC1);
    repeat (330) @(negedge clk);
    #3;
    n_checks++; if (oam_obs.size() - b_oam !== 160) begin n_errors++; $display("FAIL xfer_oam_count got %0d exp 160", oam_obs.size() - b_oam); end
    n_checks++; if (act_total - b_act !== 321) begin n_errors++; $display("FAIL xfer_active_cycles got %0d exp 321", act_total - b_act); end
    n_checks++; if (last_act_cyc !== last_woam_cyc) begin n_errors++; $display("FAIL xfer_active_tail got %0d exp %0d", last_act_cyc, last_woam_cyc); end
    n_checks++; if (dma_active !== 1'b0) begin n_errors++; $display("FAIL xfer_end_idle got %b exp 0", dma_active); end
    i = 0;
    while (exp_oam.size() > 0) begin
      e = exp_oam.pop_front();
      g = (b_oam + i < oam_obs.size()) ? oam_obs[b_oam + i] : 16'hDEAD;
      n_checks++; if (g !== e) begin n_errors++; $display("FAIL xfer_oam[%0d] got %h exp %h", i, g, e); end
      i++;
    end
    i = 0;
    while (exp_src.size() > 0) begin
      e = exp_src.pop_front();
      g = (b_src + i < src_obs.size()) ? src_obs[b_src + i] : 16'h0000;
      n_checks++; if (g !== e) begin n_errors++; $display("FAIL xfer_src[%0d] got %h exp %h", i, g, e); end
      i++;
    end
  endtask

  task automatic test_blocking;
    int b_src, b_stray, i;
    logic [15:0] e, g;
    b_src = src_obs.size(); b_stray = stray_wr;
    for (int k = 0; k < 160; k++) exp_src.push_back({8'hC1, 8'(k)});
    write_dma(8'hC1);
    repeat (10) @(negedge clk);
    A_cpu = 16'hC000; rd_cpu = 1'b1;
    #1;
    n_checks++; if (Do_cpu !== 8'hFF) begin n_errors++; $display("FAIL blk_read_data got %h exp ff", Do_cpu); end
    n_checks++; if (rd_MMU && A_MMU === 16'hC000) begin n_errors++; $display("FAIL blk_read_leak got %h exp not c000", A_MMU); end
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      A_cpu = 16'h8000; rd_cpu = 1'b0; wr_cpu = 1'b1; Di_cpu = 8'h77;
      #1;
      n_checks++; if (wr_MMU !== 1'b0) begin n_errors++; $display("FAIL blk_write_leak[%0d] got %b exp 0", p, wr_MMU); end
    end
    @(negedge clk);
    wr_cpu = 1'b0; Di_cpu = 8'h00; A_cpu = 16'hFF46; rd_cpu = 1'b1;
    #1;
    n_checks++; if (Do_cpu !== 8'hC1) begin n_errors++; $display("FAIL blk_reg_read got %h exp c1", Do_cpu); end
    @(negedge clk);
    A_cpu = 16'h0000; rd_cpu = 1'b0;
    repeat (330) @(negedge clk);
    #3;
    n_checks++; if (stray_wr - b_stray !== 0) begin n_errors++; $display("FAIL blk_stray_writes got %0d exp 0", stray_wr - b_stray); end
    n_checks++; if (src_obs.size() - b_src !== 160) begin n_errors++; $display("FAIL blk_src_count got %0d exp 160", src_obs.size() - b_src); end
    i = 0;
    while (exp_src.size() > 0) begin
      e = exp_src.pop_front();
      g = (b_src + i < src_obs.size()) ? src_obs[b_src + i] : 16'h0000;
      n_checks++; if (g !== e) begin n_errors++; $display("FAIL blk_src[%0d] got %h exp %h", i, g, e); end
      i++;
    end
  endtask

  task automatic test_echo_fold;
    int b_src, b_act, i;
    logic [15:0] e, g;
    b_src = src_obs.size(); b_act = act_total;
    for (int k = 0; k < 160; k++) exp_src.push_back({8'hC3, 8'(k)});
    write_dma(8'hE3);
    repeat (330) @(negedge clk);
    #3;
    n_checks++; if (src_obs.size() - b_src !== 160) begin n_errors++; $display("FAIL echo_src_count got %0d exp 160", src_obs.size() - b_src); end
    n_checks++; if (act_total - b_act !== 321) begin n_errors++; $display("FAIL echo_active_cycles got %0d exp 321", act_total - b_act); end
    i = 0;
    while (exp_src.size() > 0) begin
      e = exp_src.pop_front();
      g = (b_src + i < src_obs.size()) ? src_obs[b_src + i] : 16'h0000;
      n_checks++; if (g !== e) begin n_errors++; $display("FAIL echo_src[%0d] got %h exp %h", i, g, e); end
      i++;
    end
  endtask

  task automatic test_restart;
    int b_oam, b_src, b_act, w2, i;
    logic [15:0] e, g;
    b_oam = oam_obs.size(); b_src = src_obs.size(); b_act = act_total;
    // Second write lands in cycle 50 after the first: bytes 0..23 written,
    // read of byte 24 on the bus, then the new source restarts from 0.
    for (int k = 0; k < 24; k++) exp_oam.push_back({8'(k), 8'(k)});
    for (int k = 0; k < 25; k++) exp_src.push_back({8'hC1, 8'(k)});
    for (int k = 0; k < 160; k++) begin
      exp_oam.push_back({8'(k), 8'(k)});
      exp_src.push_back({8'hD0, 8'(k)});
    end
    write_dma(8'hC1);
    repeat (48) @(negedge clk);
    write_dma(8'hD0);
    w2 = w_cyc;
    repeat (330) @(negedge clk);
    #3;
    n_checks++; if (last_act_cyc - w2 !== 321) begin n_errors++; $display("FAIL rst_end_after_second got %0d exp 321", last_act_cyc - w2); end
    n_checks++; if (act_total - b_act !== 371) begin n_errors++; $display("FAIL rst_active_cycles got %0d exp 371", act_total - b_act); end
    n_checks++; if (oam_obs.size() - b_oam !== 184) begin n_errors++; $display("FAIL rst_oam_count got %0d exp 184", oam_obs.size() - b_oam); end
    i = 0;
    while (exp_oam.size() > 0) begin
      e = exp_oam.pop_front();
      g = (b_oam + i < oam_obs.size()) ? oam_obs[b_oam + i] : 16'hDEAD;
      n_checks++; if (g !== e) begin n_errors++; $display("FAIL rst_oam[%0d] got %h exp %h", i, g, e); end
      i++;
    end
    i = 0;
    while (exp_src.size() > 0) begin
      e = exp_src.pop_front();
      g = (b_src + i < src_obs.size()) ? src_obs[b_src + i] : 16'h0000;
      n_checks++; if (g !== e) begin n_errors++; $display("FAIL rst_src[%0d] got %h exp %h", i, g, e); end
      i++;
    end
  endtask

  task automatic test_reset_mid;
    int b_oam, b_act, n_held;
    bit found;
    b_oam = oam_obs.size();
    found = 1'b0;
    write_dma(8'h45);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #3;
      if (wr_OAM && A_OAM == 8'd40) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++; if (!found) begin n_errors++; $display("FAIL rm_byte40_seen got 0 exp 1"); end
    reset = 1'b1;
    #1;
    n_checks++; if ({wr_OAM, dma_active} !== 2'b00) begin n_errors++; $display("FAIL rm_drop got %b exp 00", {wr_OAM, dma_active}); end
    n_checks++; if (oam_obs.size() - b_oam !== 41) begin n_errors++; $display("FAIL rm_written_before got %0d exp 41", oam_obs.size() - b_oam); end
    A_cpu = 16'hFF46; rd_cpu = 1'b1;
    #1;
    n_checks++; if (Do_cpu !== 8'h00) begin n_errors++; $display("FAIL rm_dma_reg got %h exp 00", Do_cpu); end
    n_held = oam_obs.size();
    repeat (20) @(negedge clk);
    #3;
    n_checks++; if (oam_obs.size() !== n_held) begin n_errors++; $display("FAIL rm_no_more_writes got %0d exp %0d", oam_obs.size(), n_held); end
    @(negedge clk);
    reset = 1'b0; A_cpu = 16'h0000; rd_cpu = 1'b0;
    b_oam = oam_obs.size(); b_act = act_total;
    write_dma(8'hC1);
    repeat (330) @(negedge clk);
    #3;
    n_checks++; if (oam_obs.size() - b_oam !== 160) begin n_errors++; $display("FAIL rm_clean_count got %0d exp 160", oam_obs.size() - b_oam); end
    n_checks++; if (act_total - b_act !== 321) begin n_errors++; $display("FAIL rm_clean_active got %0d exp 321", act_total - b_act); end
    n_checks++; if (oam_obs.size() <= b_oam || oam_obs[b_oam] !== 16'h0000) begin n_errors++; $display("FAIL rm_clean_first got %h exp 0000", (oam_obs.size() > b_oam) ? oam_obs[b_oam] : 16'hDEAD); end
  endtask

  initial begin
    test_reset;
    test_passthrough;
    test_transfer;
    test_blocking;
    test_echo_fold;
    test_restart;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
